// File: rtl/tb_irq_stim_gen_if.sv
// Commit-probe inputs and forced-IRQ outputs of tb_irq_stim_gen.
// The bus-error sideband exists only when IRQ_STIM_BUSERR_EN is defined.
interface tb_irq_stim_gen_if #(
  parameter int PC_SIZE = 32
);
  logic               cmt_valid;
  logic [PC_SIZE-1:0] cmt_pc;
  logic               ext_irq;
  logic               sft_irq;
  logic               tmr_irq;
  logic               armed;
  logic               done;
  logic [31:0]        tohost_cnt;
`ifdef IRQ_STIM_BUSERR_EN
  logic               status_mie;
  logic               itcm_rsp_read;
  logic               itcm_bus_err;

  // master: commit probe side, slave: stimulus generator
  modport master (
    output cmt_valid, cmt_pc, status_mie, itcm_rsp_read,
    input  ext_irq, sft_irq, tmr_irq, armed, done, tohost_cnt, itcm_bus_err
  );
  modport slave (
    input  cmt_valid, cmt_pc, status_mie, itcm_rsp_read,
    output ext_irq, sft_irq, tmr_irq, armed, done, tohost_cnt, itcm_bus_err
  );
`else
  // master: commit probe side, slave: stimulus generator
  modport master (
    output cmt_valid, cmt_pc,
    input  ext_irq, sft_irq, tmr_irq, armed, done, tohost_cnt
  );
  modport slave (
    input  cmt_valid, cmt_pc,
    output ext_irq, sft_irq, tmr_irq, armed, done, tohost_cnt
  );
`endif
endinterface

// File: rtl/tb_irq_stim_gen.sv
// Random interrupt stimulus generator driven by the EXU commit stream.
// Define IRQ_STIM_BUSERR_EN to add the ITCM bus-error stimulus channel.
module tb_irq_stim_gen #(
  parameter int                 PC_SIZE    = 32,
  parameter int                 WAIT_W     = 10,
  parameter logic [31:0]        LFSR_SEED  = 32'h1,
  parameter logic [PC_SIZE-1:0] PC_ARM     = 32'h8000015C,
  parameter logic [PC_SIZE-1:0] PC_TOHOST  = 32'h80000086,
  parameter logic [PC_SIZE-1:0] PC_EXT_RET = 32'h800000a6,
  parameter logic [PC_SIZE-1:0] PC_SFT_RET = 32'h800000be,
  parameter logic [PC_SIZE-1:0] PC_TMR_RET = 32'h800000d6,
  parameter int unsigned        STOP_CNT   = 32
) (
  input  logic             clk,
  input  logic             rst,
  tb_irq_stim_gen_if.slave bus
);

  localparam logic [31:0]            LFSR_TAPS = 32'h80200003;
  localparam int                     CNT_W     = WAIT_W + 1;
  localparam logic [9:0]             WAIT_MASK = 10'((1 << WAIT_W) - 1);
  localparam logic [3*PC_SIZE-1:0]   RET_PCS   = {PC_TMR_RET, PC_SFT_RET, PC_EXT_RET};

  typedef enum logic [1:0] {CH_IDLE, CH_WAIT, CH_ASSERT, CH_DONE} ch_state_t;

  logic [31:0] lfsr_reg;
  logic [31:0] lfsr_next;
  logic        armed_reg;
  logic [31:0] tohost_cnt_reg;
  logic        done_reg;
  logic        hit_arm;
  logic        hit_tohost;
  logic        arm_now;
  logic        stop;
  logic [2:0]  irq_vec;
  logic [2:0]  ch_done_next;
  logic        all_done_next;

  assign hit_arm    = bus.cmt_valid && (bus.cmt_pc == PC_ARM);
  assign hit_tohost = bus.cmt_valid && (bus.cmt_pc == PC_TOHOST);
  assign stop       = (tohost_cnt_reg > STOP_CNT);
  // Channels leave IDLE on the arming commit itself so the first rise lands N cycles after it.
  assign arm_now    = armed_reg || hit_arm;
  assign lfsr_next  = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ LFSR_TAPS) : (lfsr_reg >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_reg       <= LFSR_SEED;
      armed_reg      <= 1'b0;
      tohost_cnt_reg <= '0;
      done_reg       <= 1'b0;
    end else begin
      lfsr_reg <= lfsr_next;
      if (hit_arm) begin
        armed_reg <= 1'b1;
      end
      if (hit_tohost && (tohost_cnt_reg != 32'hFFFF_FFFF)) begin
        tohost_cnt_reg <= tohost_cnt_reg + 32'd1;
      end
      done_reg <= all_done_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      ch_state_t        state_reg;
      ch_state_t        state_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             irq_reg;
      logic             irq_next;
      logic [CNT_W-1:0] reload;
      logic             hit_ret;

      assign reload  = CNT_W'(lfsr_reg[gi*10 +: 10] & WAIT_MASK) + CNT_W'(1);
      assign hit_ret = bus.cmt_valid && (bus.cmt_pc == RET_PCS[gi*PC_SIZE +: PC_SIZE]);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= CH_IDLE;
          cnt_reg   <= '0;
          irq_reg   <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          irq_reg   <= irq_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        irq_next   = 1'b0;
        case (state_reg)
          CH_IDLE: begin
            if (arm_now) begin
              state_next = CH_WAIT;
              cnt_next   = reload;
            end
          end
          CH_WAIT: begin
            if (cnt_reg == CNT_W'(1)) begin
              state_next = CH_ASSERT;
              irq_next   = 1'b1;
            end else begin
              cnt_next = cnt_reg - CNT_W'(1);
            end
          end
          CH_ASSERT: begin
            irq_next = 1'b1;
            // Stop is only honoured here, so a raised IRQ always sees its handler return.
            if (hit_ret) begin
              irq_next = 1'b0;
              if (stop) begin
                state_next = CH_DONE;
              end else begin
                state_next = CH_WAIT;
                cnt_next   = reload;
              end
            end
          end
          CH_DONE: begin
            state_next = CH_DONE;
          end
          default: begin
            state_next = CH_IDLE;
          end
        endcase
      end

      assign irq_vec[gi]      = irq_reg;
      assign ch_done_next[gi] = (state_next == CH_DONE);
    end
  endgenerate

`ifdef IRQ_STIM_BUSERR_EN
  typedef enum logic [1:0] {BE_IDLE, BE_LOW, BE_HIGH, BE_DONE} be_state_t;

  be_state_t  be_state_reg;
  be_state_t  be_state_next;
  logic [7:0] be_cnt_reg;
  logic [7:0] be_cnt_next;
  logic       high_phase_reg;
  logic       high_phase_next;
  logic [7:0] be_low_reload;
  logic [7:0] be_high_reload;

  assign be_low_reload  = 8'(lfsr_reg[3:0]) + 8'd1;
  assign be_high_reload = 8'(lfsr_reg[30:24]) + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      be_state_reg   <= BE_IDLE;
      be_cnt_reg     <= '0;
      high_phase_reg <= 1'b0;
    end else begin
      be_state_reg   <= be_state_next;
      be_cnt_reg     <= be_cnt_next;
      high_phase_reg <= high_phase_next;
    end
  end

  always_comb begin
    be_state_next   = be_state_reg;
    be_cnt_next     = be_cnt_reg;
    high_phase_next = 1'b0;
    case (be_state_reg)
      BE_IDLE: begin
        if (arm_now) begin
          be_state_next = BE_LOW;
          be_cnt_next   = be_low_reload;
        end
      end
      BE_LOW: begin
        if (stop) begin
          be_state_next = BE_DONE;
        end else if (be_cnt_reg == 8'd1) begin
          be_state_next   = BE_HIGH;
          be_cnt_next     = be_high_reload;
          high_phase_next = 1'b1;
        end else begin
          be_cnt_next = be_cnt_reg - 8'd1;
        end
      end
      BE_HIGH: begin
        high_phase_next = 1'b1;
        if (be_cnt_reg == 8'd1) begin
          high_phase_next = 1'b0;
          if (stop) begin
            be_state_next = BE_DONE;
          end else begin
            be_state_next = BE_LOW;
            be_cnt_next   = be_low_reload;
          end
        end else begin
          be_cnt_next = be_cnt_reg - 8'd1;
        end
      end
      BE_DONE: begin
        be_state_next = BE_DONE;
      end
      default: begin
        be_state_next = BE_IDLE;
      end
    endcase
  end

  assign bus.itcm_bus_err = high_phase_reg && bus.status_mie && bus.itcm_rsp_read;
  assign all_done_next    = (&ch_done_next) && (be_state_next == BE_DONE);
`else
  assign all_done_next    = &ch_done_next;
`endif

  assign bus.ext_irq    = irq_vec[0];
  assign bus.sft_irq    = irq_vec[1];
  assign bus.tmr_irq    = irq_vec[2];
  assign bus.armed      = armed_reg;
  assign bus.done       = done_reg;
  assign bus.tohost_cnt = tohost_cnt_reg;

endmodule

// File: tb/tb_tb_irq_stim_gen.sv
// Directed bench for tb_irq_stim_gen: reset, arming, IRQ timing, return gating,
// stop/done sequencing and mid-run reset.
module tb_tb_irq_stim_gen;

  localparam logic [31:0] SEED       = 32'h1;
  localparam logic [31:0] TAPS       = 32'h80200003;
  localparam logic [31:0] PC_ARM     = 32'h8000015C;
  localparam logic [31:0] PC_TOHOST  = 32'h80000086;
  localparam logic [31:0] PC_EXT_RET = 32'h800000a6;
  localparam logic [31:0] PC_SFT_RET = 32'h800000be;
  localparam logic [31:0] PC_TMR_RET = 32'h800000d6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] m_lfsr;

  tb_irq_stim_gen_if #(.PC_SIZE(32)) bus ();

  tb_irq_stim_gen #(
    .PC_SIZE    (32),
    .WAIT_W     (10),
    .LFSR_SEED  (SEED),
    .PC_ARM     (PC_ARM),
    .PC_TOHOST  (PC_TOHOST),
    .PC_EXT_RET (PC_EXT_RET),
    .PC_SFT_RET (PC_SFT_RET),
    .PC_TMR_RET (PC_TMR_RET),
    .STOP_CNT   (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  // Reference LFSR sequence: seed while in reset, one Galois step per clock after.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    bus.cmt_valid = v;
    bus.cmt_pc    = pc;
  endtask

  function automatic logic [31:0] safe_pc(input logic [31:0] pc);
    return ((pc == PC_ARM) || (pc == PC_TOHOST)) ? (pc ^ 32'h1) : pc;
  endfunction

  // Arms at the current cycle and checks the selected channel rises exactly N cycles later.
  task automatic arm_and_check_rise(input int ch, input string tag);
    logic [31:0] arm_lfsr;
    logic [9:0]  slice;
    int          n;
    int          k;
    logic        irq;
    arm_lfsr = m_lfsr;
    slice    = (ch == 0) ? arm_lfsr[9:0] : (ch == 1) ? arm_lfsr[19:10] : arm_lfsr[29:20];
    n        = int'(slice) + 1;
    drive(1'b1, PC_ARM);
    tick();
    drive(1'b0, 32'h0);
    vec_cnt++;
    if (bus.armed !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s_armed: got %b want 1", tag, bus.armed);
    end
    k   = 0;
    irq = (ch == 0) ? bus.ext_irq : (ch == 1) ? bus.sft_irq : bus.tmr_irq;
    while (!irq && k < 1100) begin
      tick();
      k++;
      irq = (ch == 0) ? bus.ext_irq : (ch == 1) ? bus.sft_irq : bus.tmr_irq;
    end
    vec_cnt++;
    if (k != n || k < 1 || k > 1024) begin
      err_cnt++;
      $display("FAIL %s_rise: irq rose %0d cycles after armed, want %0d", tag, k, n);
    end
    $display("%s: ch%0d rise after %0d cycles (expected %0d)", tag, ch, k, n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), $urandom);
      tick();
      vec_cnt++;
      if ({bus.ext_irq, bus.sft_irq, bus.tmr_irq, bus.armed, bus.done} !== 5'b0) begin
        err_cnt++;
        $display("FAIL reset_outs: got %b want 00000",
                 {bus.ext_irq, bus.sft_irq, bus.tmr_irq, bus.armed, bus.done});
      end
      vec_cnt++;
      if (bus.tohost_cnt !== 32'd0) begin
        err_cnt++;
        $display("FAIL reset_tohost: got %0d want 0", bus.tohost_cnt);
      end
    end
    rst = 1'b0;
    drive(1'b0, 32'h0);
    $display("test_reset: 3 reset cycles checked");
  endtask

  task automatic test_no_arm();
    int bad = 0;
    for (int i = 0; i < 5000; i++) begin
      if (i % 100 == 0) drive(1'b0, PC_ARM);
      else              drive(1'($urandom), safe_pc($urandom));
      tick();
      vec_cnt++;
      if ({bus.ext_irq, bus.sft_irq, bus.tmr_irq, bus.armed} !== 4'b0) begin
        err_cnt++;
        bad++;
        if (bad < 5)
          $display("FAIL no_arm_outs: cycle %0d got %b want 0000", i,
                   {bus.ext_irq, bus.sft_irq, bus.tmr_irq, bus.armed});
      end
    end
    drive(1'b0, 32'h0);
    vec_cnt++;
    if (bus.tohost_cnt !== 32'd0) begin
      err_cnt++;
      $display("FAIL no_arm_tohost: got %0d want 0", bus.tohost_cnt);
    end
    $display("test_no_arm: 5000 cycles without arm commit");
  endtask

  task automatic test_arm();
    arm_and_check_rise(0, "test_arm");
  endtask

  task automatic test_ret_gating();
    drive(1'b0, PC_EXT_RET);
    for (int i = 0; i < 4; i++) begin
      tick();
      vec_cnt++;
      if (bus.ext_irq !== 1'b1) begin
        err_cnt++;
        $display("FAIL ret_invalid_hold: got %b want 1", bus.ext_irq);
      end
    end
    drive(1'b1, PC_EXT_RET);
    tick();
    drive(1'b0, 32'h0);
    vec_cnt++;
    if (bus.ext_irq !== 1'b0) begin
      err_cnt++;
      $display("FAIL ret_valid_clear: got %b want 0", bus.ext_irq);
    end
    $display("test_ret_gating: ext_irq held without valid, cleared with valid");
  endtask

  task automatic test_stop_done();
    int k;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, PC_TOHOST);
      tick();
    end
    for (int i = 0; i < 33; i++) begin
      drive(1'b1, PC_TOHOST);
      tick();
    end
    drive(1'b0, 32'h0);
    vec_cnt++;
    if (bus.tohost_cnt !== 32'd33) begin
      err_cnt++;
      $display("FAIL stop_tohost_cnt: got %0d want 33", bus.tohost_cnt);
    end
    vec_cnt++;
    if (bus.done !== 1'b0) begin
      err_cnt++;
      $display("FAIL stop_done_early: got %b want 0", bus.done);
    end
    k = 0;
    while (!bus.done && k < 6000) begin
      if      (bus.ext_irq) drive(1'b1, PC_EXT_RET);
      else if (bus.sft_irq) drive(1'b1, PC_SFT_RET);
      else if (bus.tmr_irq) drive(1'b1, PC_TMR_RET);
      else                  drive(1'b0, 32'h0);
      tick();
      k++;
    end
    drive(1'b0, 32'h0);
    vec_cnt++;
    if (bus.done !== 1'b1) begin
      err_cnt++;
      $display("FAIL stop_done: got %b want 1 after %0d cycles", bus.done, k);
    end
    for (int i = 0; i < 1200; i++) begin
      drive(1'($urandom), (i % 7 == 0) ? PC_ARM : $urandom);
      tick();
      vec_cnt++;
      if ({bus.ext_irq, bus.sft_irq, bus.tmr_irq, bus.done} !== 4'b0001) begin
        err_cnt++;
        $display("FAIL stop_terminal: got %b want 0001",
                 {bus.ext_irq, bus.sft_irq, bus.tmr_irq, bus.done});
        break;
      end
    end
    drive(1'b0, 32'h0);
    vec_cnt++;
    if (bus.tohost_cnt !== 32'd33) begin
      err_cnt++;
      $display("FAIL stop_tohost_final: got %0d want 33", bus.tohost_cnt);
    end
    $display("test_stop_done: done after %0d cycles, tohost_cnt=%0d", k, bus.tohost_cnt);
  endtask

  task automatic test_rst_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    arm_and_check_rise(2, "test_rst_mid_tmr");
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({bus.tmr_irq, bus.armed} !== 2'b00) begin
      err_cnt++;
      $display("FAIL rst_mid_async: tmr_irq/armed got %b want 00", {bus.tmr_irq, bus.armed});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom), safe_pc($urandom));
      tick();
      vec_cnt++;
      if ({bus.ext_irq, bus.sft_irq, bus.tmr_irq, bus.armed} !== 4'b0) begin
        err_cnt++;
        $display("FAIL rst_mid_quiet: cycle %0d got %b want 0000", i,
                 {bus.ext_irq, bus.sft_irq, bus.tmr_irq, bus.armed});
        break;
      end
    end
    drive(1'b0, 32'h0);
    arm_and_check_rise(0, "test_rst_mid_rearm");
    $display("test_rst_mid: reset mid-IRQ and re-arm checked");
  endtask

  initial begin
    bus.cmt_valid = 1'b0;
    bus.cmt_pc    = 32'h0;
`ifdef IRQ_STIM_BUSERR_EN
    bus.status_mie    = 1'b0;
    bus.itcm_rsp_read = 1'b0;
`endif
    test_reset();
    test_no_arm();
    test_arm();
    test_ret_gating();
    test_stop_done();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
